pq_req_arbiter: RTL and testbench

//  Shares one hardware priority queue (pq_if-style enq/deq/kvi/kvo/empty/full) among N_REQ requesters.

---
 rtl/pq_req_arbiter_pkg.sv | 26 ++
 rtl/pq_req_arbiter_if.sv | 38 +++
 rtl/pq_req_arbiter_rr.sv | 53 +++++
 rtl/pq_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_pq_req_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pq_req_arbiter_pkg.sv
// rtl/pq_req_arbiter_pkg.sv - shared types and widths for the PQ request arbiter
// Purpose: operation encoding, key/value widths and small helpers shared by
//          the arbiter, its picker and its interface.
// Ports:   none (package).
package pq_req_arbiter_pkg;

    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;
    localparam int KV_WIDTH  = KEY_WIDTH + VAL_WIDTH;

    typedef logic [KV_WIDTH-1:0] kv_t;

    // Bit 0 means "enqueue", bit 1 means "dequeue"; REPL sets both.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ENQ  = 2'b01,
        OP_DEQ  = 2'b10,
        OP_REPL = 2'b11
    } pq_op_t;

    // True for operations that remove the current top element.
    function automatic logic op_removes(pq_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/pq_req_arbiter_if.sv
// rtl/pq_req_arbiter_if.sv - requester and PQ-side signal bundle for the arbiter
// Purpose: groups the requester handshake, the response and the PQ strobe bus.
// Ports:   req_valid/req_op/req_kv/req_ready (requesters), rsp_* (response),
//          pq_enq/pq_deq/pq_kvi/pq_kvo/pq_empty/pq_full (priority queue).
//          slave modport = arbiter, master modport = clients plus PQ.
interface pq_req_arbiter_if
    import pq_req_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) ();
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*2-1:0]        req_op;
    logic [N_REQ*KV_WIDTH-1:0] req_kv;
    logic [N_REQ-1:0]          req_ready;
    logic                      rsp_valid;
    logic [IW-1:0]             rsp_id;
    kv_t                       rsp_kv;
    logic                      rsp_err;
    logic                      pq_enq;
    logic                      pq_deq;
    kv_t                       pq_kvi;
    kv_t                       pq_kvo;
    logic                      pq_empty;
    logic                      pq_full;

    modport slave (
        input  req_valid, req_op, req_kv, pq_kvo, pq_empty, pq_full,
        output req_ready, rsp_valid, rsp_id, rsp_kv, rsp_err, pq_enq, pq_deq, pq_kvi
    );

    modport master (
        output req_valid, req_op, req_kv, pq_kvo, pq_empty, pq_full,
        input  req_ready, rsp_valid, rsp_id, rsp_kv, rsp_err, pq_enq, pq_deq, pq_kvi
    );

endinterface

// File: rtl/pq_req_arbiter_rr.sv
// rtl/pq_req_arbiter_rr.sv - N-way masked round-robin / fixed-priority picker
// Purpose: picks the first eligible index at or after ptr (round-robin), or the
//          lowest eligible index when PQ_ARB_FIXED_PRIO_EN is defined.
// Ports:   eligible (in, N), ptr (in, start index), grant (out, one-hot),
//          idx (out, winner index), any (out, some request won).
// Macro:   PQ_ARB_FIXED_PRIO_EN selects fixed priority; ptr is then ignored.
module pq_req_arbiter_rr #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

`ifdef PQ_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && eligible[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end
`else
    // Walk N positions starting at ptr, wrapping once.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && eligible[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/pq_req_arbiter.sv
// rtl/pq_req_arbiter.sv - shares one hardware priority queue among N_REQ requesters
// Purpose: grants one request at a time, issues it as ENQ/DEQ/REPL strobes,
//          holds off further grants for an op-dependent settle gap and returns
//          the removed top element to the issuing requester.
// Ports:   clk, rst (sync active-high), bus (pq_req_arbiter_if.slave):
//          requester handshake, one-cycle response, PQ strobe bus.
// Macro:   PQ_ARB_FIXED_PRIO_EN - lowest eligible index wins, pointer stays 0.
module pq_req_arbiter
    import pq_req_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ENQ_GAP  = 8,
    parameter int DEQ_GAP  = 4,
    parameter int REPL_GAP = 4
) (
    input  logic              clk,
    input  logic              rst,
    pq_req_arbiter_if.slave   bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [CW-1:0]  gap_cnt;
    pq_op_t         op_q;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    pq_op_t           win_op;
    kv_t              win_kv;
    logic             win_err;
    logic [CW-1:0]    gap_sel;

    // A full-PQ ENQ or an illegal op stays pending but must not block others.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = bus.req_valid[i]
                       && (bus.req_op[2*i +: 2] != 2'b00)
                       && !((bus.req_op[2*i +: 2] == 2'b01) && bus.pq_full);
        end
    end

    pq_req_arbiter_rr #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .idx      (win_idx),
        .any      (win_any)
    );

    assign bus.req_ready = (state == ST_IDLE && !rst) ? grant : '0;

    assign win_op  = pq_op_t'(bus.req_op[{win_idx, 1'b0} +: 2]);
    assign win_kv  = bus.req_kv[int'(win_idx)*KV_WIDTH +: KV_WIDTH];
    // The PQ empty flag is judged at the handshake edge, not at issue time.
    assign win_err = op_removes(win_op) && bus.pq_empty;

    always_comb begin
        gap_sel = '0;
        case (op_q)
            OP_ENQ:  gap_sel = CW'(ENQ_GAP);
            OP_DEQ:  gap_sel = CW'(DEQ_GAP);
            OP_REPL: gap_sel = CW'(REPL_GAP);
            default: gap_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            gap_cnt       <= '0;
            op_q          <= OP_NONE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_kv    <= '0;
            bus.rsp_err   <= 1'b0;
            bus.pq_enq    <= 1'b0;
            bus.pq_deq    <= 1'b0;
            bus.pq_kvi    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        op_q          <= win_op;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= win_idx;
                        bus.rsp_err   <= win_err;
                        bus.rsp_kv    <= (win_op == OP_ENQ || win_err) ? '0 : bus.pq_kvo;
                        bus.pq_enq    <= !win_err && win_op[0];
                        bus.pq_deq    <= !win_err && win_op[1];
                        bus.pq_kvi    <= win_kv;
`ifndef PQ_ARB_FIXED_PRIO_EN
                        ptr           <= (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
`endif
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_id    <= '0;
                    bus.rsp_kv    <= '0;
                    bus.rsp_err   <= 1'b0;
                    bus.pq_enq    <= 1'b0;
                    bus.pq_deq    <= 1'b0;
                    bus.pq_kvi    <= '0;
                    if (bus.rsp_err || gap_sel == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_sel;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (gap_cnt <= 1) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pq_req_arbiter.sv
// tb/tb_pq_req_arbiter.sv - directed self-checking bench for pq_req_arbiter
module tb_pq_req_arbiter;
    import pq_req_arbiter_pkg::*;

    localparam int N        = 4;
    localparam int ENQ_GAP  = 8;
    localparam int DEQ_GAP  = 4;
    localparam int REPL_GAP = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pq_req_arbiter_if #(.N_REQ(N)) bus ();

    pq_req_arbiter #(
        .N_REQ    (N),
        .ENQ_GAP  (ENQ_GAP),
        .DEQ_GAP  (DEQ_GAP),
        .REPL_GAP (REPL_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] kv);
        bus.req_op[2*i +: 2]  = op;
        bus.req_kv[16*i +: 16] = kv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bus.req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_kv    = '0;
        bus.pq_kvo    = '0;
        bus.pq_empty  = 1'b1;
        bus.pq_full   = 1'b0;
        do_reset();
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.pq_enq, bus.pq_deq} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b want 0000", {bus.rsp_valid, bus.rsp_err, bus.pq_enq, bus.pq_deq});
        end
        checks++;
        if ({bus.pq_kvi, bus.rsp_kv, bus.rsp_id, bus.req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_buses kvi=%h rsp_kv=%h id=%0d ready=%b want 0", bus.pq_kvi, bus.rsp_kv, bus.rsp_id, bus.req_ready);
        end
    endtask

    task automatic test_enq();
        int first;
        set_req(0, 2'b01, 16'h0F0F);
        bus.req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL enq_ready got %b want 0001", bus.req_ready);
        end
        step();
        checks++;
        if ({bus.pq_enq, bus.pq_deq, bus.rsp_valid, bus.rsp_err} !== 4'b1010) begin
            errors++;
            $display("FAIL enq_strobe enq/deq/rv/err got %b want 1010", {bus.pq_enq, bus.pq_deq, bus.rsp_valid, bus.rsp_err});
        end
        checks++;
        if (bus.pq_kvi !== 16'h0F0F || bus.rsp_id !== 2'd0 || bus.rsp_kv !== 16'h0000) begin
            errors++;
            $display("FAIL enq_data kvi=%h id=%0d rsp_kv=%h want 0f0f 0 0000", bus.pq_kvi, bus.rsp_id, bus.rsp_kv);
        end
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.req_ready != '0) begin
                first = k;
                break;
            end
        end
        bus.req_valid = '0;
        checks++;
        if (first != ENQ_GAP + 1) begin
            errors++;
            $display("FAIL enq_gap first grant at %0d want %0d", first, ENQ_GAP + 1);
        end
        idle_cycles(2);
    endtask

    task automatic test_deq();
        int next;
        bus.pq_empty = 1'b0;
        bus.pq_kvo   = 16'h0303;
        set_req(2, 2'b10, 16'h0000);
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL deq_ready got %b want 0100", bus.req_ready);
        end
        step();
        checks++;
        if ({bus.pq_enq, bus.pq_deq, bus.rsp_valid, bus.rsp_err} !== 4'b0110) begin
            errors++;
            $display("FAIL deq_strobe enq/deq/rv/err got %b want 0110", {bus.pq_enq, bus.pq_deq, bus.rsp_valid, bus.rsp_err});
        end
        checks++;
        if (bus.rsp_id !== 2'd2 || bus.rsp_kv !== 16'h0303) begin
            errors++;
            $display("FAIL deq_rsp id=%0d kv=%h want 2 0303", bus.rsp_id, bus.rsp_kv);
        end
        step();
        checks++;
        if (bus.pq_deq !== 1'b0) begin
            errors++;
            $display("FAIL deq_pulse_width pq_deq=%b want 0", bus.pq_deq);
        end
        next = -1;
        for (int k = 2; k <= 20; k++) begin
            step();
            if (bus.pq_deq === 1'b1) begin
                next = k;
                break;
            end
        end
        bus.req_valid = '0;
        checks++;
        if (next != DEQ_GAP + 2) begin
            errors++;
            $display("FAIL deq_spacing next strobe at %0d want %0d", next, DEQ_GAP + 2);
        end
        idle_cycles(DEQ_GAP + 3);
    endtask

    task automatic test_deq_empty();
        bus.pq_empty = 1'b1;
        bus.pq_kvo   = 16'hAAAA;
        set_req(1, 2'b10, 16'h0000);
        bus.req_valid = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL empty_ready got %b want 0010", bus.req_ready);
        end
        step();
        checks++;
        if ({bus.pq_enq, bus.pq_deq, bus.rsp_valid, bus.rsp_err} !== 4'b0011) begin
            errors++;
            $display("FAIL empty_rsp enq/deq/rv/err got %b want 0011", {bus.pq_enq, bus.pq_deq, bus.rsp_valid, bus.rsp_err});
        end
        checks++;
        if (bus.rsp_kv !== 16'h0000 || bus.rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL empty_data kv=%h id=%0d want 0000 1", bus.rsp_kv, bus.rsp_id);
        end
        step();
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL empty_regrant got %b want 0010", bus.req_ready);
        end
        bus.req_valid = '0;
        idle_cycles(2);
    endtask

    task automatic test_rotation();
        int got[5];
        int n;
        int exp_idx;
        do_reset();
        bus.pq_empty = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 2'b01, 16'(16'h1000 + i));
        bus.req_valid = 4'b1111;
        n = 0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                checks++;
                if (!$onehot(bus.req_ready)) begin
                    errors++;
                    $display("FAIL rot_onehot got %b want one-hot", bus.req_ready);
                end
                for (int i = 0; i < N; i++) if (bus.req_ready[i]) got[n] = i;
                n++;
            end
            step();
        end
        bus.req_valid = '0;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rot_count got %0d grants want 5", n);
        end
        for (int g = 0; g < n; g++) begin
`ifdef PQ_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = g % N;
`endif
            checks++;
            if (got[g] != exp_idx) begin
                errors++;
                $display("FAIL rot_order grant %0d got %0d want %0d", g, got[g], exp_idx);
            end
        end
        idle_cycles(ENQ_GAP + 4);
    endtask

    task automatic test_full();
        int leaked;
        do_reset();
        bus.pq_full  = 1'b1;
        bus.pq_empty = 1'b0;
        bus.pq_kvo   = 16'h0505;
        set_req(0, 2'b01, 16'h0707);
        set_req(3, 2'b11, 16'h2121);
        bus.req_valid = 4'b1001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL full_ready got %b want 1000", bus.req_ready);
        end
        step();
        bus.req_valid = 4'b0001;
        checks++;
        if ({bus.pq_enq, bus.pq_deq} !== 2'b11 || bus.pq_kvi !== 16'h2121) begin
            errors++;
            $display("FAIL full_repl enq/deq=%b kvi=%h want 11 2121", {bus.pq_enq, bus.pq_deq}, bus.pq_kvi);
        end
        checks++;
        if (bus.rsp_id !== 2'd3 || bus.rsp_kv !== 16'h0505) begin
            errors++;
            $display("FAIL full_rsp id=%0d kv=%h want 3 0505", bus.rsp_id, bus.rsp_kv);
        end
        leaked = 0;
        for (int k = 0; k < REPL_GAP + 6; k++) begin
            step();
            if (bus.req_ready != '0) leaked++;
        end
        checks++;
        if (leaked != 0) begin
            errors++;
            $display("FAIL full_hold grants while full got %0d want 0", leaked);
        end
        bus.pq_full = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL full_release got %b want 0001", bus.req_ready);
        end
        bus.req_valid = '0;
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_req(0, 2'b01, 16'h0F0F);
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.pq_enq, bus.pq_deq} !== 4'b0000 ||
            {bus.pq_kvi, bus.rsp_kv, bus.rsp_id, bus.req_ready} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs rv/err/enq/deq=%b kvi=%h kv=%h ready=%b want 0",
                     {bus.rsp_valid, bus.rsp_err, bus.pq_enq, bus.pq_deq}, bus.pq_kvi, bus.rsp_kv, bus.req_ready);
        end
        rst = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_regrant got %b want 0001", bus.req_ready);
        end
        step();
        checks++;
        if (bus.pq_enq !== 1'b1) begin
            errors++;
            $display("FAIL midrst_issue pq_enq=%b want 1", bus.pq_enq);
        end
        bus.req_valid = '0;
        idle_cycles(ENQ_GAP + 3);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_enq();
        test_deq();
        test_deq_empty();
        test_rotation();
        test_full();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
